uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between three requesters:
  - ch0: manual single byte (switch load/transmit path).
  - ch1: echo of a received byte.
  - ch2: 4-byte burst of the transmit buffer.
- Round-robin arbitration; a granted burst is atomic.
- Sits between the requester logic and the UART TX engine, and sequences the start/busy handshake.
- Supervises each frame with a start timeout.

---
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between a manual byte,
// an echo byte and an atomic 4-byte burst; supervises each frame start.
module uart_tx_arbiter #(
  parameter int unsigned START_TIMEOUT = 1023,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  input  logic [31:0] burst_data,
  output logic [2:0]  ack,
  output logic [2:0]  grant,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        burst_done,
  output logic        timeout_err,
  output logic        active
);

  localparam int unsigned TO_W  = 16;
  localparam int unsigned GAP_W = 8;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_RISE, WAIT_FALL, GAP} state_t;

  state_t             state;
  logic [1:0]         rr_ptr;
  logic [1:0]         idx;
  logic [31:0]        shreg;
  logic [TO_W-1:0]    to_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [1:0]         win_c;

  // Round-robin winner: search upward from the channel after the last owner
  always_comb begin
    win_c = 2'd0;
    case (rr_ptr)
      2'd0:    win_c = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win_c = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win_c = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= 2'd0;
      idx         <= 2'd0;
      shreg       <= 32'd0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      ack         <= 3'b000;
      grant       <= 3'b000;
      tx_start    <= 1'b0;
      tx_data     <= 8'd0;
      burst_done  <= 1'b0;
      timeout_err <= 1'b0;
      active      <= 1'b0;
    end else begin
      ack         <= 3'b000;
      tx_start    <= 1'b0;
      burst_done  <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (|req) begin
            grant  <= 3'b001 << win_c;
            rr_ptr <= win_c;
            idx    <= 2'd0;
            active <= 1'b1;
            state  <= LOAD;
            case (win_c)
              2'd0:    shreg <= {24'd0, data0};
              2'd1:    shreg <= {24'd0, data1};
              default: shreg <= burst_data;
            endcase
          end
        end

        LOAD: begin
          tx_start <= 1'b1;
          tx_data  <= shreg[7:0];
          if (idx == 2'd0) ack <= grant;
          to_cnt   <= '0;
          state    <= WAIT_RISE;
        end

        WAIT_RISE: begin
          if (tx_busy) begin
            state <= WAIT_FALL;
          end else if (to_cnt == TO_W'(START_TIMEOUT)) begin
            // Engine never accepted the frame: drop the whole transaction
            timeout_err <= 1'b1;
            grant       <= 3'b000;
            active      <= 1'b0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end

        WAIT_FALL: begin
          if (!tx_busy) begin
            if (grant[2] && (idx != 2'd3)) begin
              idx     <= idx + 2'd1;
              shreg   <= shreg >> 8;
              gap_cnt <= '0;
              state   <= (GAP_CYCLES == 0) ? LOAD : GAP;
            end else begin
              burst_done <= grant[2];
              grant      <= 3'b000;
              active     <= 1'b0;
              state      <= IDLE;
            end
          end
        end

        GAP: begin
          if ((9'(gap_cnt) + 9'd1) >= 9'(GAP_CYCLES)) state <= LOAD;
          else gap_cnt <= gap_cnt + 8'd1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural TX engine model.
module tb_uart_tx_arbiter;

  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [7:0]  data0, data1;
  logic [31:0] burst_data;
  logic [2:0]  ack, grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        burst_done, timeout_err, active;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.START_TIMEOUT(TO), .GAP_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .data0(data0), .data1(data1),
    .burst_data(burst_data), .ack(ack), .grant(grant), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .burst_done(burst_done),
    .timeout_err(timeout_err), .active(active)
  );

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
    logic       first;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   starts = 0, done_seen = 0, done_exp = 0, to_seen = 0;
  logic busy_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] outs();
    return {ack, grant, tx_start, tx_data, burst_done, timeout_err, active};
  endfunction

  task automatic push(input logic [1:0] ch, input logic [7:0] d, input logic first);
    exp_t e;
    e.ch = ch; e.data = d; e.first = first;
    sb.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input int ch);
    int n = 0;
    do begin @(negedge clk); n++; end while (!ack[ch] && n < 300);
    chk($sformatf("ack%0d_seen", ch), 32'(ack[ch]), 32'd1);
  endtask

  task automatic wait_busy(input logic lvl);
    int n = 0;
    do begin @(negedge clk); n++; end while (tx_busy !== lvl && n < 100);
    chk("busy_level", 32'(tx_busy), 32'(lvl));
  endtask

  task automatic wait_start();
    int n = 0;
    do begin @(negedge clk); n++; end while (!tx_start && n < 100);
    chk("start_seen", 32'(tx_start), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((active || tx_busy || sb.size() != 0) && n < 2000);
    chk("idle_reached", 32'(active || tx_busy || sb.size() != 0), 32'd0);
  endtask

  // TX engine: busy rises 3 cycles after a start and stays high 10 cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && busy_en) begin
        repeat (3) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Monitor: every issued byte is compared against the scoreboard head
  always @(negedge clk) begin
    if (tx_start) begin
      exp_t e;
      starts++;
      chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e.data));
        chk("grant_at_start", 32'(grant), 32'(3'b001 << e.ch));
        chk("ack_at_start", 32'(ack), e.first ? 32'(3'b001 << e.ch) : 32'd0);
      end
    end else if (ack != 3'b000) begin
      chk("stray_ack", 32'(ack), 32'd0);
    end
    if (burst_done) done_seen++;
    if (timeout_err) to_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base, n;
    reset = 1'b1; req = 3'b000; data0 = 8'd0; data1 = 8'd0; burst_data = 32'd0;
    cyc(3);
    chk("reset_outputs", 32'(outs()), 32'd0);
    reset = 1'b0;

    // Single manual byte: latency, ack and grant lifetime
    data0 = 8'h41; push(2'd0, 8'h41, 1'b1); req = 3'b001;
    @(negedge clk);
    chk("t1_grant_cycle", 32'(grant), 32'd1);
    chk("t1_no_start_yet", 32'(tx_start), 32'd0);
    @(negedge clk);
    chk("t1_start_latency", 32'(tx_start), 32'd1);
    req = 3'b000;
    wait_busy(1'b1);
    chk("t1_grant_busy", 32'(grant), 32'd1);
    wait_busy(1'b0);
    @(negedge clk);
    chk("t1_grant_released", 32'(grant), 32'd0);
    wait_idle();

    // All three requesting continuously: ch1, ch2 burst, ch0, ch1
    data0 = 8'h10; data1 = 8'h20; burst_data = 32'h04030201;
    push(2'd1, 8'h20, 1'b1);
    push(2'd2, 8'h01, 1'b1); push(2'd2, 8'h02, 1'b0);
    push(2'd2, 8'h03, 1'b0); push(2'd2, 8'h04, 1'b0);
    push(2'd0, 8'h10, 1'b1); push(2'd1, 8'h20, 1'b1);
    done_exp++;
    base = starts;
    req = 3'b111;
    n = 0;
    do begin @(negedge clk); n++; end while (starts < base + 7 && n < 1000);
    req = 3'b000;
    chk("t2_all_starts", 32'(starts - base), 32'd7);
    wait_idle();

    // Burst stays atomic while ch0 requests mid-burst; gap check
    burst_data = 32'hDDCCBBAA; data0 = 8'h77;
    push(2'd2, 8'hAA, 1'b1); push(2'd2, 8'hBB, 1'b0);
    push(2'd2, 8'hCC, 1'b0); push(2'd2, 8'hDD, 1'b0);
    push(2'd0, 8'h77, 1'b1);
    done_exp++;
    req = 3'b100;
    wait_ack(2);
    req = 3'b000;
    wait_busy(1'b1);
    wait_busy(1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_start && n < 50);
    chk("t3_gap_latency", 32'(n), 32'd4);
    req = 3'b001;
    wait_ack(0);
    chk("t3_done_before_ch0", 32'(done_seen), 32'(done_exp));
    req = 3'b000;
    wait_idle();

    // Start timeout: engine never goes busy
    busy_en = 1'b0;
    data0 = 8'h33; push(2'd0, 8'h33, 1'b1);
    req = 3'b001;
    wait_ack(0);
    req = 3'b000;
    n = 0;
    do begin @(negedge clk); n++; end while (!timeout_err && n < 100);
    chk("t4_timeout_latency", 32'(n), 32'd16);
    chk("t4_grant_cleared", 32'(grant), 32'd0);
    @(negedge clk);
    chk("t4_inactive", 32'(active), 32'd0);
    busy_en = 1'b1;
    data1 = 8'h5A; push(2'd1, 8'h5A, 1'b1);
    req = 3'b010;
    wait_ack(1);
    req = 3'b000;
    wait_idle();

    // Reset while waiting for the second burst byte to finish
    burst_data = 32'h44332211;
    push(2'd2, 8'h11, 1'b1); push(2'd2, 8'h22, 1'b0);
    req = 3'b100;
    wait_ack(2);
    req = 3'b000;
    wait_busy(1'b1);
    wait_busy(1'b0);
    wait_start();
    wait_busy(1'b1);
    cyc(2);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_reset_outputs", 32'(outs()), 32'd0);
    reset = 1'b0;
    wait_busy(1'b0);
    cyc(3);
    chk("t5_no_done", 32'(done_seen), 32'(done_exp));
    burst_data = 32'h88776655;
    push(2'd2, 8'h55, 1'b1); push(2'd2, 8'h66, 1'b0);
    push(2'd2, 8'h77, 1'b0); push(2'd2, 8'h88, 1'b0);
    done_exp++;
    req = 3'b100;
    wait_ack(2);
    req = 3'b000;
    wait_idle();

    // One-cycle request glitch is served exactly once with latched data
    base = starts;
    data1 = 8'h55; push(2'd1, 8'h55, 1'b1);
    req = 3'b010;
    @(negedge clk);
    req = 3'b000; data1 = 8'h99;
    wait_idle();
    cyc(20);
    chk("t6_single_start", 32'(starts - base), 32'd1);

    chk("burst_done_count", 32'(done_seen), 32'(done_exp));
    chk("timeout_count", 32'(to_seen), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
